cv32e40p_wb_stage: RTL and testbench

CV32E40P_WB_STAGE -- requirements
Module: cv32e40p_wb_stage

---
 rtl/cv32e40p_pkg.sv | 13 +
 rtl/cv32e40p_wb_fifo.sv | 72 +++++++
 rtl/cv32e40p_wb_stage.sv | 125 ++++++++++++
 tb/tb_cv32e40p_wb_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared writeback-stage types and constants.
package cv32e40p_pkg;

    // Default number of skid-buffer entries holding deferred APU results.
    localparam int WB_FIFO_DEPTH = 2;

    // One register-file write: destination register and data.
    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// Skid buffer for APU results that lost arbitration for the register-file
// write port. A push into a full buffer is dropped unless the same cycle
// pops, which frees a slot. Flush empties the buffer synchronously.
module cv32e40p_wb_fifo
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       push_i,
    input  wb_entry_t  push_data_i,
    input  logic       pop_i,
    output wb_entry_t  head_o,
    output logic [2:0] count_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [2:0] CNT_MAX = 3'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [2:0]            count_q;
    logic                  do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == 3'd0);
    assign full_o  = (count_q == CNT_MAX);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; flush discards everything but keeps data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_wb_stage.sv
// Writeback stage: arbitrates the single register-file write port between
// LSU writebacks and two-cycle APU results. LSU always wins; APU results that
// cannot be written immediately wait in an in-order skid buffer.
module cv32e40p_wb_stage
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        setback_i,
    input  logic        lsu_we_i,
    input  logic [5:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        apu_valid_i,
    input  logic [5:0]  apu_waddr_i,
    input  logic [31:0] apu_result_i,
    output logic        rf_we_o,
    output logic [5:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        wb_ready_o,
    output logic [2:0]  fifo_count_o,
    output logic        overflow_o,
    output logic [15:0] contention_cnt_o
);

    wb_entry_t   lsu_entry, apu_entry, fifo_head, sel_entry;
    logic        sel_we;
    logic        fifo_empty, fifo_full, fifo_drop;
    logic        push, pop;
    logic [2:0]  fifo_count;

    logic        rf_we_q;
    wb_entry_t   rf_q;
    logic        overflow_q;
    logic [15:0] cont_cnt_q;

    assign lsu_entry = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
    assign apu_entry = '{waddr: apu_waddr_i, wdata: apu_result_i};

    // An APU result must queue behind an LSU write or behind older queued results,
    // which keeps APU retirement in arrival order.
    assign push = !setback_i && apu_valid_i && (lsu_we_i || !fifo_empty);
    assign pop  = !setback_i && !lsu_we_i && !fifo_empty;

    cv32e40p_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (setback_i),
        .push_i      (push),
        .push_data_i (apu_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    // Write-port priority: LSU, then oldest buffered APU result, then direct APU bypass.
    always_comb begin
        sel_we    = 1'b0;
        sel_entry = '0;
        if (lsu_we_i) begin
            sel_we    = 1'b1;
            sel_entry = lsu_entry;
        end else if (!fifo_empty) begin
            sel_we    = 1'b1;
            sel_entry = fifo_head;
        end else if (apu_valid_i) begin
            sel_we    = 1'b1;
            sel_entry = apu_entry;
        end
    end

    // Register the selected write; address/data hold when no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_q    <= '0;
        end else if (setback_i) begin
            rf_we_q <= 1'b0;
        end else begin
            rf_we_q <= sel_we;
            if (sel_we) begin
                rf_q <= sel_entry;
            end
        end
    end

    // Sticky drop flag, cleared only by reset or setback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (setback_i) begin
            overflow_q <= 1'b0;
        end else if (fifo_drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Saturating count of every APU result that had to go through the buffer,
    // dropped ones included; setback does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_cnt_q <= '0;
        end else if (push && (cont_cnt_q != 16'hFFFF)) begin
            cont_cnt_q <= cont_cnt_q + 16'd1;
        end
    end

    assign rf_we_o          = rf_we_q;
    assign rf_waddr_o       = rf_q.waddr;
    assign rf_wdata_o       = rf_q.wdata;
    assign fifo_count_o     = fifo_count;
    assign overflow_o       = overflow_q;
    assign contention_cnt_o = cont_cnt_q;
    assign wb_ready_o       = (fifo_count < 3'(DEPTH - 1));

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_cv32e40p_wb_stage.sv
// Directed bench for the writeback stage at DEPTH=2.
module tb_cv32e40p_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        setback_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [5:0]  lsu_waddr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        apu_valid_i = 1'b0;
    logic [5:0]  apu_waddr_i = '0;
    logic [31:0] apu_result_i = '0;
    logic        rf_we_o;
    logic [5:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        wb_ready_o;
    logic [2:0]  fifo_count_o;
    logic        overflow_o;
    logic [15:0] contention_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    cv32e40p_wb_stage #(.DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .setback_i        (setback_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_waddr_i      (lsu_waddr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .apu_valid_i      (apu_valid_i),
        .apu_waddr_i      (apu_waddr_i),
        .apu_result_i     (apu_result_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .wb_ready_o       (wb_ready_o),
        .fifo_count_o     (fifo_count_o),
        .overflow_o       (overflow_o),
        .contention_cnt_o (contention_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic lw, input logic [5:0] la, input logic [31:0] ld,
                         input logic av, input logic [5:0] aa, input logic [31:0] ad);
        lsu_we_i = lw; lsu_waddr_i = la; lsu_wdata_i = ld;
        apu_valid_i = av; apu_waddr_i = aa; apu_result_i = ad;
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [5:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(rf_we_o), 32'(we));
        if (we) begin
            chk({tag, ".waddr"}, 32'(rf_waddr_o), 32'(a));
            chk({tag, ".wdata"}, rf_wdata_o, d);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".we"},    32'(rf_we_o), 32'd0);
        chk({tag, ".waddr"}, 32'(rf_waddr_o), 32'd0);
        chk({tag, ".wdata"}, rf_wdata_o, 32'd0);
        chk({tag, ".count"}, 32'(fifo_count_o), 32'd0);
        chk({tag, ".ovf"},   32'(overflow_o), 32'd0);
        chk({tag, ".cont"},  32'(contention_cnt_o), 32'd0);
        chk({tag, ".ready"}, 32'(wb_ready_o), 32'd1);
    endtask

    initial begin
        // Reset values while rst is held, no clock edge needed.
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst");
        #9 rst = 1'b0;              // released mid-cycle at t=12
        cyc(); cyc();
        chk_rf("post_rst_idle", 1'b0, 6'd0, 32'd0);

        // LSU only.
        drive(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0);
        cyc(); idle();
        chk_rf("lsu_only", 1'b1, 6'd5, 32'hDEADBEEF);
        chk("lsu_only.count", 32'(fifo_count_o), 32'd0);
        cyc();
        chk_rf("lsu_only.after", 1'b0, 6'd0, 32'd0);

        // APU alone with empty buffer bypasses it.
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd9, 32'h00000099);
        cyc(); idle();
        chk_rf("bypass", 1'b1, 6'd9, 32'h99);
        chk("bypass.count", 32'(fifo_count_o), 32'd0);
        chk("bypass.cont", 32'(contention_cnt_o), 32'd0);

        // Collision on the same register: LSU first, APU one cycle later.
        drive(1'b1, 6'd7, 32'h11, 1'b1, 6'd7, 32'h22);
        cyc(); idle();
        chk_rf("coll.n1", 1'b1, 6'd7, 32'h11);
        chk("coll.n1.count", 32'(fifo_count_o), 32'd1);
        chk("coll.cont", 32'(contention_cnt_o), 32'd1);
        cyc();
        chk_rf("coll.n2", 1'b1, 6'd7, 32'h22);
        chk("coll.n2.count", 32'(fifo_count_o), 32'd0);
        cyc();
        chk_rf("coll.n3", 1'b0, 6'd0, 32'd0);

        // Overflow: three pushes while LSU holds the port; third is dropped.
        drive(1'b1, 6'd1, 32'h101, 1'b1, 6'd10, 32'hA);
        cyc();
        chk("ovf.c1.count", 32'(fifo_count_o), 32'd1);
        chk("ovf.c1.ready", 32'(wb_ready_o), 32'd0);
        drive(1'b1, 6'd2, 32'h102, 1'b1, 6'd11, 32'hB);
        cyc();
        drive(1'b1, 6'd3, 32'h103, 1'b1, 6'd12, 32'hC);
        cyc(); idle();
        chk_rf("ovf.c3", 1'b1, 6'd3, 32'h103);
        chk("ovf.count", 32'(fifo_count_o), 32'd2);
        chk("ovf.flag", 32'(overflow_o), 32'd1);
        chk("ovf.ready", 32'(wb_ready_o), 32'd0);
        chk("ovf.cont", 32'(contention_cnt_o), 32'd4);
        cyc();
        chk_rf("ovf.drain1", 1'b1, 6'd10, 32'hA);
        cyc();
        chk_rf("ovf.drain2", 1'b1, 6'd11, 32'hB);
        chk("ovf.drain2.count", 32'(fifo_count_o), 32'd0);
        cyc();
        chk_rf("ovf.drain3", 1'b0, 6'd0, 32'd0);
        chk("ovf.sticky", 32'(overflow_o), 32'd1);
        chk("ovf.ready_back", 32'(wb_ready_o), 32'd1);

        // Setback on an empty buffer clears the sticky flag.
        setback_i = 1'b1;
        cyc(); setback_i = 1'b0;
        chk("sb0.flag", 32'(overflow_o), 32'd0);

        // Simultaneous push and pop with one entry queued.
        drive(1'b1, 6'd1, 32'h55, 1'b1, 6'd20, 32'h111);
        cyc();
        chk("pp.c1.count", 32'(fifo_count_o), 32'd1);
        drive(1'b0, 6'd0, 32'd0, 1'b1, 6'd21, 32'h222);
        cyc(); idle();
        chk_rf("pp.head", 1'b1, 6'd20, 32'h111);
        chk("pp.count", 32'(fifo_count_o), 32'd1);
        chk("pp.cont", 32'(contention_cnt_o), 32'd6);
        cyc();
        chk_rf("pp.next", 1'b1, 6'd21, 32'h222);
        chk("pp.next.count", 32'(fifo_count_o), 32'd0);

        // Setback with two entries and overflow set; that cycle's inputs ignored.
        drive(1'b1, 6'd2, 32'h1, 1'b1, 6'd30, 32'h301);
        cyc();
        drive(1'b1, 6'd2, 32'h2, 1'b1, 6'd31, 32'h302);
        cyc();
        drive(1'b1, 6'd2, 32'h3, 1'b1, 6'd32, 32'h303);
        cyc();
        chk("sb.pre.count", 32'(fifo_count_o), 32'd2);
        chk("sb.pre.flag", 32'(overflow_o), 32'd1);
        chk("sb.pre.cont", 32'(contention_cnt_o), 32'd9);
        drive(1'b1, 6'd4, 32'h44, 1'b1, 6'd33, 32'h304);
        setback_i = 1'b1;
        cyc(); setback_i = 1'b0; idle();
        chk("sb.count", 32'(fifo_count_o), 32'd0);
        chk("sb.flag", 32'(overflow_o), 32'd0);
        chk("sb.we", 32'(rf_we_o), 32'd0);
        chk("sb.cont", 32'(contention_cnt_o), 32'd9);
        cyc();
        chk("sb.after.we", 32'(rf_we_o), 32'd0);

        // Reset asserted while the buffer is draining.
        drive(1'b1, 6'd3, 32'h5, 1'b1, 6'd40, 32'h401);
        cyc();
        drive(1'b1, 6'd3, 32'h6, 1'b1, 6'd41, 32'h402);
        cyc(); idle();
        chk("mid.pre.cont", 32'(contention_cnt_o), 32'd11);
        cyc();
        chk_rf("mid.pop", 1'b1, 6'd40, 32'h401);
        chk("mid.pop.count", 32'(fifo_count_o), 32'd1);
        #3 rst = 1'b1;
        #1 chk_reset_vals("mid_rst");
        #2 rst = 1'b0;
        cyc();
        chk("mid.rel1.we", 32'(rf_we_o), 32'd0);
        chk("mid.rel1.count", 32'(fifo_count_o), 32'd0);
        cyc();
        chk("mid.rel2.we", 32'(rf_we_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
